stall_fifo_buffer: RTL

Parametrised, pointer-based successor to the 8-slot stall buffer in the pipeline front end. It sits between a producer stage and the stall manager. While `stall` is high, valid input words are held in a circular FIFO. When the stall releases, they drain in order, one word per cycle. When the FIFO is empty, input passes through with one cycle of latency. It also drives full, almost-full and empty status, an occupancy count, and an arbiter request.

---
 rtl/stall_fifo_buffer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/stall_fifo_buffer.sv
// Stall buffer: circular FIFO that holds producer words while downstream is stalled,
// drains them in order, and bypasses with one cycle of latency when empty.
// Optional dropped-word counter enabled by defining STALL_FIFO_OVF_CNT_EN.
module stall_fifo_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 6
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    input  logic                       stall,
    input  logic                       flush,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    output logic                       full,
    output logic                       almost_full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       arbiter_req
`ifdef STALL_FIFO_OVF_CNT_EN
    ,
    output logic [15:0]                ovf_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              arb_req_q, arb_req_d;
    logic              mem_we;
    logic              full_w;

    assign full_w = (count_q == CW'(DEPTH));

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        arb_req_d   = arb_req_q;
        mem_we      = 1'b0;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            arb_req_d   = 1'b0;
        end else if (stall) begin
            out_valid_d = 1'b0;
            arb_req_d   = (count_q != '0) | in_valid;
            if (in_valid && !full_w) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                count_d  = count_q + CW'(1);
            end
        end else if (count_q != '0) begin
            // When full, wr_ptr == rd_ptr: the read sees the old word before the write lands.
            out_data_d  = mem[rd_ptr_q];
            out_valid_d = 1'b1;
            arb_req_d   = 1'b1;
            rd_ptr_d    = rd_ptr_q + AW'(1);
            if (in_valid) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                count_d  = count_q - CW'(1);
            end
        end else begin
            out_data_d  = in_data;
            out_valid_d = in_valid;
            arb_req_d   = in_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            arb_req_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            arb_req_q   <= arb_req_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

`ifdef STALL_FIFO_OVF_CNT_EN
    logic [15:0] ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (flush) begin
            ovf_d = '0;
        end else if (stall && in_valid && full_w && (ovf_q != '1)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_count = ovf_q;
`endif

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign arbiter_req = arb_req_q;
    assign count       = count_q;
    assign full        = full_w;
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CW'(AFULL_LVL));

endmodule
